// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and constants for the elevator controller
package elevator_pkg;

  localparam int NUM_FLOORS = 16;
  localparam int FLOOR_W    = 4;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

endpackage

// File: rtl/elevator_req_scan.sv
// rtl/elevator_req_scan.sv - locates pending calls relative to the car position
module elevator_req_scan
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  floor_t                current_floor,
  output logic                  req_above,
  output logic                  req_below,
  output logic                  req_here,
  output floor_t                nearest_above,
  output floor_t                nearest_below
);

  // Nearest call in each direction; descending/ascending sweeps leave the closest match last.
  always_comb begin
    req_above     = 1'b0;
    req_below     = 1'b0;
    nearest_above = current_floor;
    nearest_below = current_floor;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(current_floor))) begin
        req_above     = 1'b1;
        nearest_above = floor_t'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(current_floor))) begin
        req_below     = 1'b1;
        nearest_below = floor_t'(i);
      end
    end
    req_here = pending[current_floor];
  end

endmodule

// File: rtl/elevator.sv
// rtl/elevator.sv - single-car SCAN elevator controller with travel and door timers
module elevator
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_CYCLES = 2,
  parameter int DOOR_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] floor_buttons,
  input  logic                  door_open_button,
  input  logic                  door_close_button,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    floor_indicator,
  output logic                  door_open,
  output logic                  moving_up,
  output logic                  moving_down
);

  localparam int TW = $clog2(FLOOR_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(FLOOR_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);
  localparam floor_t TOP_FLOOR = floor_t'(NUM_FLOORS - 1);

  state_t                  state, state_n;
  dir_t                    dir, dir_n;
  logic [NUM_FLOORS-1:0]   pending, pending_n, req_vec;
  floor_t                  floor_n, ind_n, up_floor, down_floor;
  logic [TW-1:0]           tcnt, tcnt_n;
  logic [DW-1:0]           dcnt, dcnt_n;
  logic                    req_above, req_below, req_here;
  floor_t                  nearest_above, nearest_below;

  // Calls arriving this cycle are scheduled at once, so a call at the car's floor never lingers.
  assign req_vec    = pending | floor_buttons;
  assign up_floor   = current_floor + floor_t'(1);
  assign down_floor = current_floor - floor_t'(1);

  elevator_req_scan u_scan (
    .pending       (req_vec),
    .current_floor (current_floor),
    .req_above     (req_above),
    .req_below     (req_below),
    .req_here      (req_here),
    .nearest_above (nearest_above),
    .nearest_below (nearest_below)
  );

  // Next-state, counters, request clearing and indicator selection.
  always_comb begin
    state_n   = state;
    dir_n     = dir;
    floor_n   = current_floor;
    ind_n     = floor_indicator;
    pending_n = req_vec;
    tcnt_n    = '0;
    dcnt_n    = '0;
    case (state)
      IDLE: begin
        ind_n = current_floor;
        if (req_here || door_open_button) begin
          state_n                  = DOOR_OPEN;
          pending_n[current_floor] = 1'b0;
        end else if (req_above && ((dir == UP) || !req_below)) begin
          state_n = MOVE_UP;
          dir_n   = UP;
          ind_n   = nearest_above;
        end else if (req_below) begin
          state_n = MOVE_DOWN;
          dir_n   = DOWN;
          ind_n   = nearest_below;
        end
      end
      MOVE_UP: begin
        if (req_above) ind_n = nearest_above;
        if (tcnt != T_LAST) begin
          tcnt_n = tcnt + TW'(1);
        end else if (current_floor == TOP_FLOOR) begin
          state_n = IDLE;
          ind_n   = current_floor;
        end else begin
          floor_n = up_floor;
          if (req_vec[up_floor]) begin
            state_n             = DOOR_OPEN;
            pending_n[up_floor] = 1'b0;
            ind_n               = up_floor;
          end else if (!req_above) begin
            state_n = IDLE;
            ind_n   = up_floor;
          end
        end
      end
      MOVE_DOWN: begin
        if (req_below) ind_n = nearest_below;
        if (tcnt != T_LAST) begin
          tcnt_n = tcnt + TW'(1);
        end else if (current_floor == '0) begin
          state_n = IDLE;
          ind_n   = current_floor;
        end else begin
          floor_n = down_floor;
          if (req_vec[down_floor]) begin
            state_n               = DOOR_OPEN;
            pending_n[down_floor] = 1'b0;
            ind_n                 = down_floor;
          end else if (!req_below) begin
            state_n = IDLE;
            ind_n   = down_floor;
          end
        end
      end
      DOOR_OPEN: begin
        ind_n                    = current_floor;
        pending_n[current_floor] = 1'b0;
        if (door_open_button || req_here) begin
          dcnt_n = '0;
        end else if (door_close_button || (dcnt == D_LAST)) begin
          state_n = IDLE;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; status flags follow the next state so they stay exclusive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      dir             <= UP;
      pending         <= '0;
      tcnt            <= '0;
      dcnt            <= '0;
      current_floor   <= '0;
      floor_indicator <= '0;
      door_open       <= 1'b0;
      moving_up       <= 1'b0;
      moving_down     <= 1'b0;
    end else begin
      state           <= state_n;
      dir             <= dir_n;
      pending         <= pending_n;
      tcnt            <= tcnt_n;
      dcnt            <= dcnt_n;
      current_floor   <= floor_n;
      floor_indicator <= ind_n;
      door_open       <= (state_n == DOOR_OPEN);
      moving_up       <= (state_n == MOVE_UP);
      moving_down     <= (state_n == MOVE_DOWN);
    end
  end

endmodule

// File: tb/tb_elevator.sv
// tb/tb_elevator.sv - directed vector bench for the elevator controller
module tb_elevator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] floor_buttons = '0;
  logic        door_open_button = 1'b0;
  logic        door_close_button = 1'b0;
  logic [3:0]  current_floor, floor_indicator;
  logic        door_open, moving_up, moving_down;

  int tests = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] btn;
    logic        ob;
    logic        cb;
    int          w;
    logic [3:0]  fl;
    logic [3:0]  ind;
    logic        dr;
    logic        up;
    logic        dn;
  } vec_t;

  vec_t vecs[$];

  elevator dut (
    .clk               (clk),
    .reset             (reset),
    .floor_buttons     (floor_buttons),
    .door_open_button  (door_open_button),
    .door_close_button (door_close_button),
    .current_floor     (current_floor),
    .floor_indicator   (floor_indicator),
    .door_open         (door_open),
    .moving_up         (moving_up),
    .moving_down       (moving_down)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic cmp(input string name, input string field, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", name, field, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] fl, input logic [3:0] ind,
                           input logic dr, input logic up, input logic dn);
    cmp(name, "current_floor", int'(current_floor), int'(fl));
    cmp(name, "floor_indicator", int'(floor_indicator), int'(ind));
    cmp(name, "door_open", int'(door_open), int'(dr));
    cmp(name, "moving_up", int'(moving_up), int'(up));
    cmp(name, "moving_down", int'(moving_down), int'(dn));
    cmp(name, "status_onehot", int'(door_open) + int'(moving_up) + int'(moving_down) <= 1 ? 1 : 0, 1);
  endtask

  task automatic add(input string name, input logic [15:0] btn, input logic ob, input logic cb,
                     input int w, input logic [3:0] fl, input logic [3:0] ind,
                     input logic dr, input logic up, input logic dn);
    vec_t v;
    v.name = name; v.btn = btn; v.ob = ob; v.cb = cb; v.w = w;
    v.fl = fl; v.ind = ind; v.dr = dr; v.up = up; v.dn = dn;
    vecs.push_back(v);
  endtask

  task automatic wait_door(input logic val, input int budget, input string name);
    int n = 0;
    while (door_open !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (door_open !== val) begin
      errors++;
      $display("FAIL %s door_open got %0b expected %0b within %0d cycles", name, door_open, val, budget);
    end
  endtask

  task automatic pulse_buttons(input logic [15:0] b);
    floor_buttons = b;
    @(negedge clk);
    floor_buttons = '0;
  endtask

  initial begin
    // Each record: drive inputs across one rising edge, idle w more edges, then compare.
    add("up_start",    16'h0008, 0, 0, 0,  0, 3, 0, 1, 0);
    add("up_f1",       16'h0000, 0, 0, 1,  1, 3, 0, 1, 0);
    add("up_f2",       16'h0000, 0, 0, 1,  2, 3, 0, 1, 0);
    add("arrive_f3",   16'h0000, 0, 0, 1,  3, 3, 1, 0, 0);
    add("dwell_f3",    16'h0000, 0, 0, 6,  3, 3, 1, 0, 0);
    add("close_f3",    16'h0000, 0, 0, 0,  3, 3, 0, 0, 0);
    add("down_start",  16'h0001, 0, 0, 0,  3, 0, 0, 0, 1);
    add("down_f2",     16'h0000, 0, 0, 1,  2, 0, 0, 0, 1);
    add("down_f1",     16'h0000, 0, 0, 1,  1, 0, 0, 0, 1);
    add("arrive_f0",   16'h0000, 0, 0, 1,  0, 0, 1, 0, 0);
    add("close_f0",    16'h0000, 0, 0, 7,  0, 0, 0, 0, 0);
    add("f0_cleared",  16'h0000, 0, 0, 3,  0, 0, 0, 0, 0);
    add("open_btn",    16'h0000, 1, 0, 0,  0, 0, 1, 0, 0);
    add("dwell_c4",    16'h0000, 0, 0, 3,  0, 0, 1, 0, 0);
    add("reopen_c5",   16'h0000, 1, 0, 0,  0, 0, 1, 0, 0);
    add("restarted",   16'h0000, 0, 0, 3,  0, 0, 1, 0, 0);
    add("close_btn",   16'h0000, 0, 1, 0,  0, 0, 0, 0, 0);
    add("open_again",  16'h0000, 1, 0, 0,  0, 0, 1, 0, 0);
    add("dwell_c3",    16'h0000, 0, 0, 2,  0, 0, 1, 0, 0);
    add("open_close",  16'h0000, 1, 1, 0,  0, 0, 1, 0, 0);
    add("oc_restart",  16'h0000, 0, 0, 6,  0, 0, 1, 0, 0);
    add("oc_close",    16'h0000, 0, 0, 0,  0, 0, 0, 0, 0);
    add("scan_start",  16'h0200, 0, 0, 0,  0, 9, 0, 1, 0);
    add("scan_f5",     16'h0000, 0, 0, 9,  5, 9, 0, 1, 0);
    add("scan_call",   16'h0082, 0, 0, 0,  5, 7, 0, 1, 0);
    add("scan_stop7",  16'h0000, 0, 0, 2,  7, 7, 1, 0, 0);
    add("scan_idle7",  16'h0000, 0, 0, 7,  7, 7, 0, 0, 0);
    add("scan_keepup", 16'h0000, 0, 0, 0,  7, 9, 0, 1, 0);
    add("scan_stop9",  16'h0000, 0, 0, 3,  9, 9, 1, 0, 0);
    add("scan_idle9",  16'h0000, 0, 0, 7,  9, 9, 0, 0, 0);
    add("scan_rev",    16'h0000, 0, 0, 0,  9, 1, 0, 0, 1);
    add("scan_stop1",  16'h0000, 0, 0, 15, 1, 1, 1, 0, 0);

    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_out("reset", 0, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      floor_buttons     = vecs[k].btn;
      door_open_button  = vecs[k].ob;
      door_close_button = vecs[k].cb;
      @(negedge clk);
      floor_buttons     = '0;
      door_open_button  = 1'b0;
      door_close_button = 1'b0;
      repeat (vecs[k].w) @(negedge clk);
      check_out(vecs[k].name, vecs[k].fl, vecs[k].ind, vecs[k].dr, vecs[k].up, vecs[k].dn);
    end

    // Reset in the middle of a trip drops the car and every pending call.
    wait_door(1'b0, 20, "close_f1");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_out("reset_idle", 0, 0, 0, 0, 0);
    pulse_buttons(16'h8000);
    repeat (4) @(negedge clk);
    check_out("mid_motion", 2, 15, 0, 1, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_out("reset_motion", 0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    check_out("pending_lost", 0, 0, 0, 0, 0);

    // Top floor: car stops at 15 and never steps past it.
    pulse_buttons(16'h8000);
    wait_door(1'b1, 40, "reach_top");
    check_out("at_top", 15, 15, 1, 0, 0);
    wait_door(1'b0, 12, "top_close");
    repeat (4) @(negedge clk);
    check_out("top_idle", 15, 15, 0, 0, 0);
    pulse_buttons(16'h8000);
    check_out("call_here", 15, 15, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
